imm_enc: RTL and testbench

Immediate encoder for the RV32I datapath, the inverse of the immediate generator. It takes a base instruction word, a format select and a 32-bit immediate, and emits the instruction word with the immediate scattered into the format's bit fields, plus a range/alignment error flag. A pseudo-format `LI` expands a 32-bit constant load into one or two real instructions. The block sits in the debug/boot instruction-injection path, ahead of the instruction fetch mux, with valid/ready handshakes on both sides.

---
 rtl/imm_enc.sv | 168 ++++++++++++++++
 tb/tb_imm_enc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_enc.sv
// imm_enc: RV32I immediate encoder, the inverse of the immediate generator.
// Scatters a 32-bit immediate into the bit fields of the selected format and
// flags values that do not fit. The LI pseudo-format expands a constant load
// into ADDI, LUI, or LUI+ADDI.
//
// Handshake: a request transfers on a rising edge with in_valid_i && in_ready_o;
// an output word transfers on a rising edge with out_valid_o && out_ready_i.
// out_valid_o never drops without a transfer (except on reset), and the
// presented word holds stable while it waits.
module imm_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  sel_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] inst_o,
  output logic        err_o,
  output logic        out_last_o
);

  localparam logic [2:0] SEL_I  = 3'b001;
  localparam logic [2:0] SEL_S  = 3'b010;
  localparam logic [2:0] SEL_B  = 3'b011;
  localparam logic [2:0] SEL_U  = 3'b100;
  localparam logic [2:0] SEL_J  = 3'b101;
  localparam logic [2:0] SEL_LI = 3'b110;

  // IDLE: nothing presented; HOLD: final word presented;
  // HOLD_LUI: LUI presented with the ADDI parked in pend_q.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    HOLD_LUI = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  // Combinational encoder results for the current request.
  logic [31:0] enc_inst;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_pend;

  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [4:0]  rd;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        accept;

  // Signed-range checks: the bits above the field's sign bit must all match it.
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // LUI upper part rounds up when the low 12 bits will be sign-extended
  // negative by ADDI; adding 0x800 and keeping [31:12] is the same as adding imm[11].
  assign rd    = inst_i[11:7];
  assign li_hi = imm_i[31:12] + {19'd0, imm_i[11]};
  assign li_lo = imm_i[11:0];

  assign out_valid_o = (state_q != IDLE);
  assign in_ready_o  = !out_valid_o || (out_ready_i && last_q);
  assign accept      = in_valid_i && in_ready_o;
  assign inst_o      = inst_q;
  assign err_o       = err_q;
  assign out_last_o  = last_q;

  // Field placement and representability check for the selected format.
  always_comb begin
    enc_inst = inst_i;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_pend = {li_lo, rd, 3'b000, rd, 7'h13};
    case (sel_i)
      SEL_I: begin
        enc_inst = {imm_i[11:0], inst_i[19:0]};
        enc_err  = !fits12;
      end
      SEL_S: begin
        enc_inst = {imm_i[11:5], inst_i[24:12], imm_i[4:0], inst_i[6:0]};
        enc_err  = !fits12;
      end
      SEL_B: begin
        enc_inst = {imm_i[12], imm_i[10:5], inst_i[24:12], imm_i[4:1], imm_i[11], inst_i[6:0]};
        enc_err  = !fits13 || imm_i[0];
      end
      SEL_U: begin
        enc_inst = {imm_i[31:12], inst_i[11:0]};
        enc_err  = |imm_i[11:0];
      end
      SEL_J: begin
        enc_inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], inst_i[11:0]};
        enc_err  = !fits21 || imm_i[0];
      end
      SEL_LI: begin
        if (fits12) begin
          enc_inst = {imm_i[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          enc_inst = {li_hi, rd, 7'h37};
          enc_two  = (li_lo != 12'd0);
        end
      end
      default: begin
        enc_inst = inst_i;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    err_d   = err_q;
    last_d  = last_q;
    pend_d  = pend_q;
    if (accept) begin
      inst_d  = enc_inst;
      err_d   = enc_err;
      last_d  = !enc_two;
      pend_d  = enc_pend;
      state_d = enc_two ? HOLD_LUI : HOLD;
    end else begin
      case (state_q)
        HOLD: begin
          if (out_ready_i) state_d = IDLE;
        end
        HOLD_LUI: begin
          if (out_ready_i) begin
            inst_d  = pend_q;
            err_d   = 1'b0;
            last_d  = 1'b1;
            state_d = HOLD;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and output registers; reset discards any parked ADDI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: a vector table of single requests streamed with the
// consumer always ready, then hand sequences for two-word LI, back-pressure,
// reset in the middle of an LI and an illegal select.
module tb_imm_enc;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  sel_i;
  logic [31:0] inst_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic        err_o;
  logic        out_last_o;

  imm_enc dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sel_i       (sel_i),
    .inst_i      (inst_i),
    .imm_i       (imm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .err_o       (err_o),
    .out_last_o  (out_last_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] e_inst;
    logic        e_err;
    logic        two;
    logic [31:0] e_inst2;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  // Scoreboard: expected words {last, err, inst} in output order.
  logic [33:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_word(input logic [31:0] w, input logic e, input logic l);
    exp_q.push_back({l, e, w});
  endfunction

  // Driver: present a request, wait (bounded) for in_ready_o, transfer it.
  task automatic send(input logic [2:0] s, input logic [31:0] ins, input logic [31:0] im);
    int n;
    sel_i      = s;
    inst_i     = ins;
    imm_i      = im;
    in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) chk("accept_timeout", 34'(in_ready_o), 34'd1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk("latency_valid", 34'(out_valid_o), 34'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 34'(exp_q.size()), 34'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    sel_i       = 3'b000;
    inst_i      = 32'h0;
    imm_i       = 32'h0;

    vecs[0]  = '{3'b001, 32'h00000013, 32'hFFFFFFFF, 32'hFFF00013, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{3'b001, 32'h00000013, 32'h00000800, 32'h80000013, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{3'b011, 32'h00000063, 32'hFFFFFFFE, 32'hFE000FE3, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{3'b011, 32'h00000063, 32'h00000003, 32'h00000163, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{3'b010, 32'h00002023, 32'hFFFFFFFC, 32'hFE002E23, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{3'b010, 32'hFFFFFFFF, 32'h00000000, 32'h01FFF07F, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{3'b100, 32'h00000537, 32'hABCDE000, 32'hABCDE537, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{3'b100, 32'h00000537, 32'h00001001, 32'h00001537, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{3'b101, 32'h000000EF, 32'h00000800, 32'h001000EF, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{3'b101, 32'h000000EF, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{3'b101, 32'h000000EF, 32'h00100000, 32'h800000EF, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{3'b110, 32'hFFFFF57F, 32'h000007FF, 32'h7FF00513, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{3'b110, 32'h00000080, 32'h00010000, 32'h000100B7, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{3'b110, 32'h00000100, 32'hFFFFF800, 32'h80000113, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{3'b110, 32'h00000180, 32'h00000800, 32'h000011B7, 1'b0, 1'b1, 32'h80018193};
    vecs[15] = '{3'b000, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{3'b011, 32'h00000063, 32'h00000FFE, 32'h7E000FE3, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{3'b011, 32'h00000063, 32'h00001000, 32'h80000063, 1'b1, 1'b0, 32'h0};
    vecs[18] = '{3'b001, 32'h00000013, 32'hFFFFF7FF, 32'h7FF00013, 1'b1, 1'b0, 32'h0};

    // Monitor: every output transfer must match the head of the expected queue.
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {out_last_o, err_o, inst_o}, 34'h0);
          end else begin
            chk("word", {out_last_o, err_o, inst_o}, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 34'(out_valid_o), 34'd0);
    chk("rst_inst", 34'(inst_o), 34'd0);
    chk("rst_err", 34'(err_o), 34'd0);
    chk("rst_last", 34'(out_last_o), 34'd0);
    chk("rst_ready", 34'(in_ready_o), 34'd1);

    // Table: stream all vectors with the consumer always ready.
    out_ready_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].two) begin
        push_word(vecs[i].e_inst, 1'b0, 1'b0);
        push_word(vecs[i].e_inst2, 1'b0, 1'b1);
      end else begin
        push_word(vecs[i].e_inst, vecs[i].e_err, 1'b1);
      end
      send(vecs[i].sel, vecs[i].inst, vecs[i].imm);
    end
    drain();

    // Two-word LI: LUI then ADDI, no new request taken during the LUI cycle.
    push_word(32'h123462B7, 1'b0, 1'b0);
    push_word(32'hFFF28293, 1'b0, 1'b1);
    send(3'b110, 32'h00000280, 32'h12345FFF);
    chk("li_lui_inst", 34'(inst_o), 34'h123462B7);
    chk("li_lui_last", 34'(out_last_o), 34'd0);
    chk("li_lui_ready", 34'(in_ready_o), 34'd0);
    @(posedge clk);
    #1;
    chk("li_addi_inst", 34'(inst_o), 34'hFFF28293);
    chk("li_addi_last", 34'(out_last_o), 34'd1);
    drain();

    // Back-pressure for 5 cycles, then release with a new request waiting.
    out_ready_i = 1'b0;
    push_word(32'hFFF00013, 1'b0, 1'b1);
    send(3'b001, 32'h00000013, 32'hFFFFFFFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_inst", 34'(inst_o), 34'hFFF00013);
      chk("bp_valid", 34'(out_valid_o), 34'd1);
      chk("bp_ready", 34'(in_ready_o), 34'd0);
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    push_word(32'hABCDE537, 1'b0, 1'b1);
    send(3'b100, 32'h00000537, 32'hABCDE000);
    chk("b2b_inst", 34'(inst_o), 34'hABCDE537);
    drain();

    // Reset while the LUI is presented; a request offered during reset is dropped.
    out_ready_i = 1'b0;
    send(3'b110, 32'h00000280, 32'h12345FFF);
    @(negedge clk);
    chk("mid_li_lui", 34'(inst_o), 34'h123462B7);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    in_valid_i = 1'b1;
    sel_i      = 3'b001;
    inst_i     = 32'h00000013;
    imm_i      = 32'h00000005;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    in_valid_i = 1'b0;
    chk("mid_rst_valid", 34'(out_valid_o), 34'd0);
    chk("mid_rst_inst", 34'(inst_o), 34'd0);
    chk("mid_rst_last", 34'(out_last_o), 34'd0);
    chk("mid_rst_ready", 34'(in_ready_o), 34'd1);
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 34'(out_valid_o), 34'd0);
    end
    @(posedge clk);
    #1;

    // Illegal select 111 passes the instruction through with the error flag.
    push_word(32'h12345678, 1'b1, 1'b1);
    send(3'b111, 32'h12345678, 32'h00000001);
    chk("ill_inst", 34'(inst_o), 34'h12345678);
    chk("ill_err", 34'(err_o), 34'd1);
    drain();

    chk("final_queue", 34'(exp_q.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
